// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the shifter_pipe barrel-shifter pipeline:
//   - DEFAULT_N : default data width
//   - op_t      : operation encoding (OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR)
//   - op_is_err : flags reserved op codes, and the rotates when the rotate
//                 feature is compiled out
// Configuration macro: SHIFTER_ROTATE_EN (defined -> ROL/ROR are legal ops).
// -----------------------------------------------------------------------------
package shifter_pkg;

    localparam int DEFAULT_N = 16;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_t;

    // Any op the pipeline will not execute is passed through unchanged with
    // the error flag set, so the decision is made once at the pipe entrance.
    function automatic logic op_is_err(input logic [2:0] op);
        logic err;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: err = 1'b0;
`ifdef SHIFTER_ROTATE_EN
            OP_ROL, OP_ROR:         err = 1'b0;
`endif
            default:                err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// -----------------------------------------------------------------------------
// shifter_stage
// One register stage of the logarithmic shifter. Stage K shifts its operand by
// 2**K when count bit K is set (and the request is not in error), otherwise
// the operand passes through. Count, op, error and valid travel alongside.
// Configuration macro: SHIFTER_ROTATE_EN (defined -> rotate wrap logic built).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_adv               stage loads its input this cycle (pipeline not stalled)
//   i_flush             clear the valid bit (wins over i_adv)
//   i_valid/i_data/i_cnt/i_op/i_err   request from the previous stage
//   o_valid/o_data/o_cnt/o_op/o_err   registered request to the next stage
//   o_zero              registered "o_data == 0"
// -----------------------------------------------------------------------------
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int C = $clog2(N),
    parameter int K = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_adv,
    input  logic         i_flush,
    input  logic         i_valid,
    input  logic [N-1:0] i_data,
    input  logic [C-1:0] i_cnt,
    input  op_t          i_op,
    input  logic         i_err,
    output logic         o_valid,
    output logic [N-1:0] o_data,
    output logic [C-1:0] o_cnt,
    output op_t          o_op,
    output logic         o_err,
    output logic         o_zero
);

    localparam int SHIFT = 1 << K;

    logic [N-1:0] w_shifted;
    logic [N-1:0] w_next;

    logic         r_valid;
    logic [N-1:0] r_data;
    logic [C-1:0] r_cnt;
    op_t          r_op;
    logic         r_err;
    logic         r_zero;

    // NOTE: every variable written here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_shifted = i_data;
        case (i_op)
            OP_SLL:  w_shifted = i_data << SHIFT;
            OP_SRL:  w_shifted = i_data >> SHIFT;
            OP_SRA:  w_shifted = N'($signed(i_data) >>> SHIFT);
`ifdef SHIFTER_ROTATE_EN
            OP_ROL:  w_shifted = (i_data << SHIFT) | (i_data >> (N - SHIFT));
            OP_ROR:  w_shifted = (i_data >> SHIFT) | (i_data << (N - SHIFT));
`endif
            default: w_shifted = i_data;
        endcase
        w_next = (i_cnt[K] && !i_err) ? w_shifted : i_data;
    end

    // NOTE: the datapath registers are reset as well as the valid bit, because
    // the result and its flags must read as zero the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_op    <= OP_SLL;
            r_err   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            r_data  <= w_next;
            r_cnt   <= i_cnt;
            r_op    <= i_op;
            r_err   <= i_err;
            r_zero  <= (w_next == '0);
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_cnt   = r_cnt;
    assign o_op    = r_op;
    assign o_err   = r_err;
    assign o_zero  = r_zero;

endmodule

// File: rtl/shifter_pipe.sv
// -----------------------------------------------------------------------------
// shifter_pipe
// C-stage pipelined barrel shifter (SLL, SRL, SRA, and optionally ROL/ROR)
// with valid/ready handshakes on both sides and a synchronous flush.
// Latency is C cycles from acceptance; the whole pipe stalls while a result
// is held waiting for out_ready.
// Configuration macro: SHIFTER_ROTATE_EN (undefined -> ROL/ROR are reserved).
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready                request handshake
//   in_data[N], in_cnt[C], in_op[3]  operand, shift amount, operation
//   flush                            drop everything in flight at next edge
//   out_valid/out_ready              result handshake
//   out_data[N], out_zero, out_err   result, zero flag, error flag
// -----------------------------------------------------------------------------
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int C = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [C-1:0] in_cnt,
    input  logic [2:0]   in_op,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_zero,
    output logic         out_err
);

    // Index 0 is the pipe entrance; index k+1 is the output of stage k.
    logic         w_valid [C+1];
    logic [N-1:0] w_data  [C+1];
    logic [C-1:0] w_cnt   [C+1];
    op_t          w_op    [C+1];
    logic         w_err   [C+1];
    logic         w_zero  [C];
    logic         w_adv;

    // The only thing that can block the pipe is an unaccepted result at the end.
    assign w_adv = !(w_valid[C] && !out_ready);

    assign w_valid[0] = in_valid;
    assign w_data[0]  = in_data;
    assign w_cnt[0]   = in_cnt;
    assign w_op[0]    = op_t'(in_op);
    assign w_err[0]   = op_is_err(in_op);

    for (genvar k = 0; k < C; k++) begin : g_stage
        shifter_stage #(
            .N (N),
            .C (C),
            .K (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_adv   (w_adv),
            .i_flush (flush),
            .i_valid (w_valid[k]),
            .i_data  (w_data[k]),
            .i_cnt   (w_cnt[k]),
            .i_op    (w_op[k]),
            .i_err   (w_err[k]),
            .o_valid (w_valid[k+1]),
            .o_data  (w_data[k+1]),
            .o_cnt   (w_cnt[k+1]),
            .o_op    (w_op[k+1]),
            .o_err   (w_err[k+1]),
            .o_zero  (w_zero[k])
        );
    end

    assign in_ready  = w_adv;
    assign out_valid = w_valid[C];
    assign out_data  = w_data[C];
    // Flags are only meaningful alongside a valid result.
    assign out_zero  = w_zero[C-1] && w_valid[C];
    assign out_err   = w_err[C]    && w_valid[C];

endmodule
